// File: rtl/linear_layer_sequencer.sv
// rtl/linear_layer_sequencer.sv - row/chunk sequencer for a tiled linear layer
//
// Walks M output rows; each row streams C = K/N input chunks through a
// weight fetcher with LAT cycles of latency, then drains the fetch pipeline
// and presents the row result on a valid/ready handshake.
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   start            begin a full layer pass (only honoured while idle)
//   busy, done       pass in progress / one-cycle pulse after the last row
//   fetch_ready      fetcher can accept a beat
//   fetch_ce         fetcher clock enable, one per accepted input chunk
//   x_valid/x_ready  input chunk handshake
//   acc_clr, acc_en, bias_add   accumulator controls aligned to fetcher data
//   out_valid/out_ready         row result handshake
//   row_idx, chunk_idx          current row and chunk position
module linear_layer_sequencer #(
  parameter int M   = 6,
  parameter int N   = 4,
  parameter int K   = 16,
  parameter int LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic                         fetch_ready,
  output logic                         fetch_ce,
  input  logic                         x_valid,
  output logic                         x_ready,
  output logic                         acc_clr,
  output logic                         acc_en,
  output logic                         bias_add,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(M)-1:0]         row_idx,
  output logic [$clog2(K/N)-1:0]       chunk_idx
);

  localparam int C  = K / N;
  localparam int RW = $clog2(M);
  localparam int CW = $clog2(C);
  localparam int DW = $clog2(LAT + 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t          state;
  logic [DW-1:0]   drain_cnt;
  logic            done_r;
  logic            beat;

  // Delay line lane per stage: {beat, first chunk of row, last chunk of row}
  logic [2:0]            tap;
  logic [LAT-1:0][2:0]   dl;
  logic [LAT-1:0][2:0]   dl_shift;

  assign busy      = (state != IDLE);
  assign x_ready   = (state == RUN) && fetch_ready;
  assign beat      = x_ready && x_valid;
  assign fetch_ce  = beat;
  assign out_valid = (state == OUT);
  assign done      = done_r;

  assign tap = {beat, chunk_idx == '0, chunk_idx == CW'(C - 1)};

  generate
    if (LAT > 1) begin : g_deep
      assign dl_shift = {dl[LAT-2:0], tap};
    end else begin : g_one
      assign dl_shift = tap;
    end
  endgenerate

  // The flags only matter when their stage also carries a beat
  assign acc_en   = dl[LAT-1][2];
  assign acc_clr  = dl[LAT-1][2] && dl[LAT-1][1];
  assign bias_add = dl[LAT-1][2] && dl[LAT-1][0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row_idx   <= '0;
      chunk_idx <= '0;
      drain_cnt <= '0;
      done_r    <= 1'b0;
      dl        <= '0;
    end else begin
      done_r <= 1'b0;
      dl     <= dl_shift;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            row_idx   <= '0;
            chunk_idx <= '0;
          end
        end
        RUN: begin
          if (beat) begin
            if (chunk_idx == CW'(C - 1)) begin
              chunk_idx <= '0;
              drain_cnt <= '0;
              state     <= DRAIN;
            end else begin
              chunk_idx <= chunk_idx + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Covers LAT cycles for the last beat to reach the accumulator
          // plus one cycle for the accumulator to settle.
          if (drain_cnt == DW'(LAT)) begin
            state <= OUT;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (row_idx == RW'(M - 1)) begin
              row_idx <= '0;
              state   <= IDLE;
              done_r  <= 1'b1;
            end else begin
              row_idx <= row_idx + 1'b1;
              state   <= RUN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/linear_layer_sequencer.md
LINEAR_LAYER_SEQUENCER -- requirements
Module: linear_layer_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- M, 6, number of output rows (neurons).
- N, 4, lanes per fetch beat (matches fetcher N).
- K, 16, input features per row; K SHALL be a multiple of N; C = K/N chunks per row.
- LAT, 1, cycles from fetch_ce to valid fetcher data_out/bias.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, begin one full layer pass.
- busy, out, 1, pass in progress.
- done, out, 1, one-cycle pulse at pass end.
- fetch_ready, in, 1, fetcher in_ready.
- fetch_ce, out, 1, fetcher clock enable, one per beat.
- x_valid, in, 1, input chunk available.
- x_ready, out, 1, sequencer accepts input chunk.
- acc_clr, out, 1, clear accumulator with current product.
- acc_en, out, 1, accumulate fetcher output.
- bias_add, out, 1, add fetcher bias this cycle.
- out_valid, out, 1, row result valid.
- out_ready, in, 1, downstream accepts result.
- row_idx, out, $clog2(M), current row.
- chunk_idx, out, $clog2(C), current chunk within row.

Function
REQ-003 States SHALL be IDLE, RUN, DRAIN, OUT.
REQ-004 IDLE: start=1 -> RUN next cycle, row_idx=0, chunk_idx=0; start in any other state SHALL be ignored.
REQ-005 RUN: x_ready = fetch_ready; beat = x_ready && x_valid; fetch_ce = beat (combinational); no beat -> hold counters, no stall limit.
REQ-006 Each beat increments chunk_idx; beat at chunk_idx=C-1 -> chunk_idx=0, state DRAIN.
REQ-007 acc_en SHALL equal beat delayed exactly LAT cycles (shift register, length LAT).
REQ-008 acc_clr SHALL assert with the delayed acc_en of chunk 0; bias_add with the delayed acc_en of chunk C-1; neither otherwise.
REQ-009 DRAIN SHALL last exactly LAT+1 cycles, then OUT; x_ready=0, fetch_ce=0 in DRAIN, OUT, IDLE.
REQ-010 OUT: out_valid=1, row_idx stable until out_ready=1; on handshake with row_idx<M-1 -> row_idx+1, RUN; with row_idx=M-1 -> IDLE, row_idx=0.
REQ-011 done SHALL pulse one cycle, the cycle after the final OUT handshake (state IDLE).
REQ-012 busy SHALL be 1 in RUN, DRAIN, OUT; 0 in IDLE.
REQ-013 start asserted in the same cycle done pulses SHALL be accepted (IDLE).
REQ-014 Counters SHALL wrap only as specified; row_idx never exceeds M-1, chunk_idx never exceeds C-1.

Reset
REQ-015 rst=1 at any clock edge SHALL force IDLE, row_idx=0, chunk_idx=0, clear the LAT delay line, and drive busy, done, fetch_ce, x_ready, acc_clr, acc_en, bias_add, out_valid to 0.
REQ-016 Reset mid-pass SHALL abandon the pass with no done pulse and no acc_en/bias_add from beats issued before reset.

Verification
REQ-017 Full pass, defaults, x_valid=fetch_ready=out_ready=1, start in cycle 0: beats cycles 1-4, acc_en 2-5, acc_clr 2, bias_add 5, DRAIN 5-6, out_valid 7; row 1 beats from cycle 8; 6 rows x 7 cycles; done cycle 43; busy 1-42.
REQ-018 x_valid low cycles 2-3 of row 0: beats 1,4,5,6; acc_en 2,5,6,7; chunk_idx holds 1 during stall; out_valid cycle 9.
REQ-019 fetch_ready low 3 cycles mid-row: x_ready=0, fetch_ce=0 those cycles; no counter advance; results unaffected.
REQ-020 out_ready low 5 cycles in row 2 OUT: out_valid and row_idx=2 held 5 cycles; no beats; row 3 resumes after handshake.
REQ-021 rst pulsed in DRAIN of row 3: next cycle all outputs 0, IDLE; no done; new start runs a clean pass from row 0.
REQ-022 start held high through a pass: ignored while busy; new pass starts in done cycle.
